beam_event: RTL and testbench

BEAM_EVENT -- requirements
Module: beam_event

---
 rtl/plusmaze_pkg.sv | 11 +
 rtl/edge_detect.sv | 21 ++
 rtl/beam_event.sv | 90 +++++++++
 tb/tb_beam_event.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/plusmaze_pkg.sv
// Shared types and constants for the plus-maze sensor blocks.
package plusmaze_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HIGH = 1'b1
  } beam_state_e;

  localparam int EVT_CNT_W = 16;

endpackage

// File: rtl/edge_detect.sv
// Registers a synchronous level and flags rising/falling edges in the detection cycle.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev;

  // prev clears on reset so a level already high at release reads as a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= d;
  end

  assign rise = d & ~prev;
  assign fall = ~d & prev;

endmodule

// File: rtl/beam_event.sv
// Beam-break event qualifier: measures high time, latches qualified events, flags drops.
module beam_event
  import plusmaze_pkg::*;
#(
  parameter int MIN_DURATION = 1000,
  parameter int DUR_WIDTH    = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clean,
  input  logic                 ack,
  input  logic                 clr_overflow,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic                 event_valid,
  output logic [DUR_WIDTH-1:0] event_duration,
  output logic [EVT_CNT_W-1:0] event_count,
  output logic                 overflow
);

  localparam logic [DUR_WIDTH-1:0] DUR_MAX = '1;

  beam_state_e          state;
  logic [DUR_WIDTH-1:0] counter;
  logic                 rise, fall;
  logic                 qual_fall, accept, drop;

  edge_detect u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (clean),
    .rise (rise),
    .fall (fall)
  );

  assign qual_fall = (state == HIGH) && fall && (32'(counter) >= MIN_DURATION);
  // an ack in the same cycle frees the slot, so the new event is taken rather than dropped
  assign accept    = qual_fall && (!event_valid || ack);
  assign drop      = qual_fall && event_valid && !ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      case (state)
        IDLE: if (rise) begin
          state   <= HIGH;
          counter <= DUR_WIDTH'(1);
        end
        HIGH: begin
          if (fall)                             state   <= IDLE;
          else if (clean && counter != DUR_MAX) counter <= counter + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise;
      fall_pulse <= fall;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_valid    <= 1'b0;
      event_duration <= '0;
      event_count    <= '0;
      overflow       <= 1'b0;
    end else begin
      if (accept) begin
        event_valid    <= 1'b1;
        event_duration <= counter;
        event_count    <= event_count + 1'b1;
      end else if (ack) begin
        event_valid <= 1'b0;
      end
      // a drop wins over a same-cycle clear
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_beam_event.sv
// Self-checking bench for beam_event: directed scenarios plus randomized run vs a reference model.
module tb_beam_event;

  localparam int MIN  = 4;
  localparam int DW   = 24;
  localparam int DWS  = 4;
  localparam int DMAX = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clean = 1'b0, ack = 1'b0, clr_overflow = 1'b0;
  logic rise_pulse, fall_pulse, event_valid, overflow;
  logic [DW-1:0] event_duration;
  logic [15:0]   event_count;

  logic clean_s = 1'b0;
  logic rise_s, fall_s, valid_s, ovf_s;
  logic [DWS-1:0] dur_s;
  logic [15:0]    cnt_s;

  int n_checks = 0, n_pass = 0, n_rise = 0, n_fall = 0;

  always #5 clk = ~clk;

  beam_event #(.MIN_DURATION(MIN), .DUR_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .clean(clean), .ack(ack), .clr_overflow(clr_overflow),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .event_valid(event_valid),
    .event_duration(event_duration), .event_count(event_count), .overflow(overflow)
  );

  beam_event #(.MIN_DURATION(MIN), .DUR_WIDTH(DWS)) dut_s (
    .clk(clk), .rst_n(rst_n), .clean(clean_s), .ack(1'b0), .clr_overflow(1'b0),
    .rise_pulse(rise_s), .fall_pulse(fall_s), .event_valid(valid_s),
    .event_duration(dur_s), .event_count(cnt_s), .overflow(ovf_s)
  );

  // Reference model: tracks the length of the current high run and applies the event rules.
  logic        m_prev, m_rise, m_fall, m_valid, m_ovf;
  int          m_len;
  logic [DW-1:0] m_dur;
  logic [15:0] m_cnt;

  always @(posedge clk or negedge rst_n) begin : model
    int  sat_len;
    bit  q;
    if (!rst_n) begin
      m_prev <= 0; m_len <= 0; m_rise <= 0; m_fall <= 0;
      m_valid <= 0; m_dur <= '0; m_cnt <= '0; m_ovf <= 0;
    end else begin
      sat_len = (m_len > DMAX) ? DMAX : m_len;
      q = !clean && m_prev && (sat_len >= MIN);
      m_prev <= clean;
      m_rise <= clean && !m_prev;
      m_fall <= !clean && m_prev;
      m_len  <= clean ? (m_prev ? m_len + 1 : 1) : 0;
      if (clr_overflow) m_ovf <= 0;
      if (q && (!m_valid || ack)) begin
        m_valid <= 1;
        m_dur   <= sat_len[DW-1:0];
        m_cnt   <= m_cnt + 16'd1;
      end else if (q) begin
        m_ovf <= 1;
      end else if (ack) begin
        m_valid <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rise_pulse) n_rise++;
    if (fall_pulse) n_fall++;
  endtask

  task automatic pulse_high(input int n, input logic ack_at_fall);
    n_rise = 0; n_fall = 0;
    clean = 1;
    repeat (n) tick();
    clean = 0; ack = ack_at_fall;
    tick();
    ack = 0;
    repeat (2) tick();
  endtask

  task automatic do_ack();
    ack = 1; tick(); ack = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; clean = 0; ack = 0; clr_overflow = 0;
    #3;
    n_checks++; if ({rise_pulse, fall_pulse, event_valid, overflow} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {rise_pulse, fall_pulse, event_valid, overflow}); else n_pass++;
    n_checks++; if (event_duration !== '0) $display("FAIL reset_dur got %0d want 0", event_duration); else n_pass++;
    n_checks++; if (event_count !== 16'd0) $display("FAIL reset_cnt got %0d want 0", event_count); else n_pass++;
    @(negedge clk); rst_n = 1;
    tick();
    n_checks++; if (rise_pulse !== 1'b0) $display("FAIL reset_idle_rise got %b want 0", rise_pulse); else n_pass++;
  endtask

  task automatic test_short();
    pulse_high(3, 0);
    n_checks++; if (n_rise != 1 || n_fall != 1) $display("FAIL short_pulses got r%0d f%0d want r1 f1", n_rise, n_fall); else n_pass++;
    n_checks++; if (event_valid !== 1'b0) $display("FAIL short_valid got %b want 0", event_valid); else n_pass++;
    n_checks++; if (event_count !== 16'd0) $display("FAIL short_cnt got %0d want 0", event_count); else n_pass++;
  endtask

  task automatic test_qualified();
    pulse_high(6, 0);
    n_checks++; if (n_rise != 1 || n_fall != 1) $display("FAIL qual_pulses got r%0d f%0d want r1 f1", n_rise, n_fall); else n_pass++;
    n_checks++; if (event_valid !== 1'b1) $display("FAIL qual_valid got %b want 1", event_valid); else n_pass++;
    n_checks++; if (event_duration !== 24'd6) $display("FAIL qual_dur got %0d want 6", event_duration); else n_pass++;
    n_checks++; if (event_count !== 16'd1) $display("FAIL qual_cnt got %0d want 1", event_count); else n_pass++;
    do_ack();
    n_checks++; if (event_valid !== 1'b0) $display("FAIL qual_ack got %b want 0", event_valid); else n_pass++;
  endtask

  task automatic test_drop();
    pulse_high(5, 0);
    pulse_high(7, 0);
    n_checks++; if (event_duration !== 24'd5) $display("FAIL drop_dur got %0d want 5", event_duration); else n_pass++;
    n_checks++; if (event_count !== 16'd2) $display("FAIL drop_cnt got %0d want 2", event_count); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL drop_ovf got %b want 1", overflow); else n_pass++;
    clr_overflow = 1; tick(); clr_overflow = 0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL drop_clr got %b want 0", overflow); else n_pass++;
    do_ack();
  endtask

  task automatic test_simul_ack();
    pulse_high(5, 0);
    pulse_high(8, 1);
    n_checks++; if (event_valid !== 1'b1) $display("FAIL simack_valid got %b want 1", event_valid); else n_pass++;
    n_checks++; if (event_duration !== 24'd8) $display("FAIL simack_dur got %0d want 8", event_duration); else n_pass++;
    n_checks++; if (event_count !== 16'd4) $display("FAIL simack_cnt got %0d want 4", event_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL simack_ovf got %b want 0", overflow); else n_pass++;
    do_ack();
  endtask

  task automatic test_saturation();
    clean_s = 1;
    repeat (20) tick();
    clean_s = 0;
    repeat (2) tick();
    n_checks++; if (valid_s !== 1'b1) $display("FAIL sat_valid got %b want 1", valid_s); else n_pass++;
    n_checks++; if (dur_s !== 4'd15) $display("FAIL sat_dur got %0d want 15", dur_s); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clean = 1;
    repeat (3) tick();
    #2 rst_n = 0;
    #1;
    n_checks++; if ({rise_pulse, fall_pulse, event_valid, overflow} !== 4'b0) $display("FAIL rmid_flags got %b want 0000", {rise_pulse, fall_pulse, event_valid, overflow}); else n_pass++;
    n_checks++; if (event_count !== 16'd0 || event_duration !== '0) $display("FAIL rmid_regs got cnt %0d dur %0d want 0 0", event_count, event_duration); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1;
    n_checks++; if (rise_pulse !== 1'b0) $display("FAIL rmid_pre_rise got %b want 0", rise_pulse); else n_pass++;
    tick();
    n_checks++; if (rise_pulse !== 1'b1) $display("FAIL rmid_rise got %b want 1", rise_pulse); else n_pass++;
    repeat (4) tick();
    clean = 0;
    repeat (2) tick();
    n_checks++; if (event_valid !== 1'b1 || event_duration !== 24'd5) $display("FAIL rmid_event got v%b dur %0d want v1 dur 5", event_valid, event_duration); else n_pass++;
    n_checks++; if (event_count !== 16'd1) $display("FAIL rmid_cnt got %0d want 1", event_count); else n_pass++;
    do_ack();
  endtask

  task automatic test_random();
    logic [DW+19:0] got, exp;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(4) == 0) clean = ~clean;
      ack          = ($urandom_range(7) == 0);
      clr_overflow = ($urandom_range(11) == 0);
      tick();
      got = {rise_pulse, fall_pulse, event_valid, overflow, event_duration, event_count};
      exp = {m_rise, m_fall, m_valid, m_ovf, m_dur, m_cnt};
      n_checks++;
      if (got !== exp) $display("FAIL rand_cyc%0d got %h want %h", i, got, exp);
      else n_pass++;
    end
    clean = 0; ack = 0; clr_overflow = 0;
  endtask

  initial begin
    test_reset();
    test_short();
    test_qualified();
    test_drop();
    test_simul_ack();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
